// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit.
package hazard_pkg;

  localparam int TUSE_W = 2;
  localparam int TNEW_W = 2;

  // Source operand is not read by the instruction.
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  // Operand source select.
  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // Tnew one stage later, saturating at zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Down-counter that reports the mult/div unit busy until it reaches zero.
module md_busy_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load restarts the count; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register; reset aborts any running countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard unit: shadow E/M/W pipeline, stall/flush, forwarding
// selects, mult/div interlock and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   d_rs,
  input  logic [RA_W-1:0]   d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [RA_W-1:0]   d_dst,
  input  logic [1:0]        d_tnew,
  input  logic              d_md_use,
  input  logic              d_md_start,
  input  logic              d_md_div,
  output logic              stall,
  output logic              flush_e,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  // Shadow pipeline registers.
  logic [RA_W-1:0]   e_rs_q, e_rs_d;
  logic [RA_W-1:0]   e_rt_q, e_rt_d;
  logic [RA_W-1:0]   e_dst_q, e_dst_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic              e_md_start_q, e_md_start_d;
  logic              e_md_div_q, e_md_div_d;
  logic [RA_W-1:0]   m_rt_q, m_rt_d;
  logic [RA_W-1:0]   m_dst_q, m_dst_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [RA_W-1:0]   w_dst_q, w_dst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              hz_rs;
  logic              hz_rt;
  logic              md_hz;
  logic [MD_W-1:0]   md_load_val;

  // A source is late if a producer in E or M still needs more cycles than
  // the consumer can wait. Register 0 and unused operands never conflict.
  function automatic logic src_hazard(
    input logic [RA_W-1:0]   src,
    input logic [TUSE_W-1:0] tuse,
    input logic [RA_W-1:0]   e_dst,
    input logic [TNEW_W-1:0] e_tnew,
    input logic [RA_W-1:0]   m_dst,
    input logic [TNEW_W-1:0] m_tnew
  );
    if (src == '0 || tuse == TUSE_NONE) begin
      return 1'b0;
    end
    return ((src == e_dst) && (e_tnew > tuse)) ||
           ((src == m_dst) && (m_tnew > tuse));
  endfunction

  // M wins over W, but only once its result exists; W results are always final.
  function automatic fwd_sel_t fwd_pick(
    input logic [RA_W-1:0]   src,
    input logic [RA_W-1:0]   m_dst,
    input logic [TNEW_W-1:0] m_tnew,
    input logic [RA_W-1:0]   w_dst
  );
    if (m_dst != '0 && src == m_dst && m_tnew == '0) begin
      return FWD_M;
    end else if (w_dst != '0 && src == w_dst) begin
      return FWD_W;
    end
    return FWD_GRF;
  endfunction

  // Same-cycle hazard detection and forwarding selects.
  always_comb begin
    hz_rs    = src_hazard(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    hz_rt    = src_hazard(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    md_hz    = d_md_use && (md_busy || e_md_start_q);
    stall    = hz_rs || hz_rt || md_hz;
    flush_e  = stall;
    fwd_d_rs = fwd_pick(d_rs, m_dst_q, m_tnew_q, w_dst_q);
    fwd_d_rt = fwd_pick(d_rt, m_dst_q, m_tnew_q, w_dst_q);
    fwd_e_rs = fwd_pick(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_e_rt = fwd_pick(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_m_rt = (w_dst_q != '0) && (m_rt_q == w_dst_q);
  end

  // Next shadow state: a stall sends a bubble into E; M and W always advance.
  always_comb begin
    e_rs_d       = d_rs;
    e_rt_d       = d_rt;
    e_dst_d      = d_dst;
    e_tnew_d     = d_tnew;
    e_md_start_d = d_md_start;
    e_md_div_d   = d_md_div;
    if (stall) begin
      e_rs_d       = '0;
      e_rt_d       = '0;
      e_dst_d      = '0;
      e_tnew_d     = '0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
    end
    m_rt_d   = e_rt_q;
    m_dst_d  = e_dst_q;
    m_tnew_d = tnew_dec(e_tnew_q);
    w_dst_d  = m_dst_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Shadow pipeline and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_dst_q      <= '0;
      e_tnew_q     <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_rt_q       <= '0;
      m_dst_q      <= '0;
      m_tnew_q     <= '0;
      w_dst_q      <= '0;
      stall_cnt_q  <= '0;
    end else begin
      e_rs_q       <= e_rs_d;
      e_rt_q       <= e_rt_d;
      e_dst_q      <= e_dst_d;
      e_tnew_q     <= e_tnew_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      m_rt_q       <= m_rt_d;
      m_dst_q      <= m_dst_d;
      m_tnew_q     <= m_tnew_d;
      w_dst_q      <= w_dst_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign md_load_val = e_md_div_q ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);

  md_busy_timer #(
    .W (MD_W)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (e_md_start_q),
    .load_val (md_load_val),
    .busy     (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// checked every cycle against a timestamp-based pipeline model.
module tb_hazard_ctrl;

  localparam int RA_W    = 5;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [RA_W-1:0]  d_rs, d_rt, d_dst;
  logic [1:0]       d_tuse_rs, d_tuse_rt, d_tnew;
  logic             d_md_use, d_md_start, d_md_div;
  logic             stall, flush_e, fwd_m_rt, md_busy;
  logic [1:0]       fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec;
  int n_mis;

  hazard_ctrl #(
    .RA_W(RA_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .flush_e(flush_e),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: in-flight instructions as (regs, absolute cycle their result is ready).
  // Index 0 = E, 1 = M, 2 = W.
  int              cyc;
  logic [RA_W-1:0] p_rs[0:2];
  logic [RA_W-1:0] p_rt[0:2];
  logic [RA_W-1:0] p_dst[0:2];
  int              p_ready[0:2];
  bit              p_md[0:2];
  bit              p_div[0:2];
  int              md_t0;
  int              md_lat;
  int              m_cnt;
  bit              m_stall_last;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      p_rs[i] = '0; p_rt[i] = '0; p_dst[i] = '0;
      p_ready[i] = 0; p_md[i] = 0; p_div[i] = 0;
    end
    md_t0 = -1000000;
    md_lat = 0;
    m_cnt = 0;
    m_stall_last = 0;
  endtask

  function automatic bit m_busy();
    return (cyc > md_t0) && (cyc <= md_t0 + md_lat);
  endfunction

  function automatic bit m_late(input logic [RA_W-1:0] s, input logic [1:0] tuse);
    if (s == '0 || tuse == 2'd3) return 0;
    for (int a = 0; a < 2; a++)
      if (p_dst[a] == s && p_ready[a] > cyc + int'(tuse)) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return m_late(d_rs, d_tuse_rs) || m_late(d_rt, d_tuse_rt) ||
           (d_md_use && (p_md[0] || m_busy()));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] s);
    if (s != '0 && p_dst[1] == s && p_ready[1] <= cyc) return 2'b10;
    if (s != '0 && p_dst[2] == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge();
    bit st;
    st = m_stall();
    if (st && m_cnt < CNT_MAX) m_cnt++;
    if (p_md[0]) begin
      md_t0  = cyc;
      md_lat = p_div[0] ? DIV_LAT : MUL_LAT;
    end
    cyc++;
    for (int i = 2; i > 0; i--) begin
      p_rs[i] = p_rs[i-1]; p_rt[i] = p_rt[i-1]; p_dst[i] = p_dst[i-1];
      p_ready[i] = p_ready[i-1]; p_md[i] = p_md[i-1]; p_div[i] = p_div[i-1];
    end
    if (st) begin
      p_rs[0] = '0; p_rt[0] = '0; p_dst[0] = '0;
      p_ready[0] = 0; p_md[0] = 0; p_div[0] = 0;
    end else begin
      p_rs[0] = d_rs; p_rt[0] = d_rt; p_dst[0] = d_dst;
      p_ready[0] = cyc + int'(d_tnew); p_md[0] = d_md_start; p_div[0] = d_md_div;
    end
    m_stall_last = st;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic check_all();
    bit         e_st, e_busy, e_mrt;
    logic [1:0] e_drs, e_drt, e_ers, e_ert;
    int         e_cnt;
    if (reset) begin
      e_st = 0; e_busy = 0; e_mrt = 0; e_cnt = 0;
      e_drs = 0; e_drt = 0; e_ers = 0; e_ert = 0;
    end else begin
      e_st   = m_stall();
      e_busy = m_busy();
      e_cnt  = m_cnt;
      e_drs  = m_fwd(d_rs);
      e_drt  = m_fwd(d_rt);
      e_ers  = m_fwd(p_rs[0]);
      e_ert  = m_fwd(p_rt[0]);
      e_mrt  = (p_dst[2] != '0) && (p_rt[1] == p_dst[2]);
    end
    cmp("stall", 32'(stall), 32'(e_st));
    cmp("flush_e", 32'(flush_e), 32'(e_st));
    cmp("md_busy", 32'(md_busy), 32'(e_busy));
    cmp("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
    cmp("fwd_d_rs", 32'(fwd_d_rs), 32'(e_drs));
    cmp("fwd_d_rt", 32'(fwd_d_rt), 32'(e_drt));
    cmp("fwd_e_rs", 32'(fwd_e_rs), 32'(e_ers));
    cmp("fwd_e_rt", 32'(fwd_e_rt), 32'(e_ert));
    cmp("fwd_m_rt", 32'(fwd_m_rt), 32'(e_mrt));
  endtask

  task automatic half();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic tick();
    half();
    adv();
  endtask

  task automatic set_d(input int rs, input int tr, input int rt, input int tt,
                       input int dst, input int tn, input int mu, input int ms, input int mdv);
    d_rs = RA_W'(rs); d_tuse_rs = 2'(tr);
    d_rt = RA_W'(rt); d_tuse_rt = 2'(tt);
    d_dst = RA_W'(dst); d_tnew = 2'(tn);
    d_md_use = (mu != 0); d_md_start = (ms != 0); d_md_div = (mdv != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    model_clear();
    half();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int nst;
    bit done;
    n_vec = 0;
    n_mis = 0;
    cyc = 0;
    reset = 1'b0;
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    model_clear();
    #2;
    do_reset();
    half();
    cmp("reset_cnt", 32'(stall_cnt), 0);
    cmp("reset_stall", 32'(stall), 0);
    adv();

    // lw $1 ; add $2,$1,$3
    set_d(0, 3, 0, 3, 1, 2, 0, 0, 0);
    tick();
    set_d(1, 1, 3, 1, 2, 1, 0, 0, 0);
    half(); cmp("t1_stall", 32'(stall), 1); cmp("t1_flush", 32'(flush_e), 1);
    adv();
    half(); cmp("t1_release", 32'(stall), 0);
    adv();
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    half(); cmp("t1_fwd_e_rs", 32'(fwd_e_rs), 1); cmp("t1_cnt", 32'(stall_cnt), 1);
    adv();

    // add $1 ; beq $1,$0
    do_reset();
    set_d(0, 3, 0, 3, 1, 1, 0, 0, 0);
    tick();
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0);
    half(); cmp("t2_stall", 32'(stall), 1);
    adv();
    half(); cmp("t2_release", 32'(stall), 0); cmp("t2_fwd_d_rs", 32'(fwd_d_rs), 2);
    adv();

    // lw $1 ; beq $1
    do_reset();
    set_d(0, 3, 0, 3, 1, 2, 0, 0, 0);
    tick();
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0);
    half(); cmp("t3_stall1", 32'(stall), 1);
    adv();
    half(); cmp("t3_stall2", 32'(stall), 1);
    adv();
    half(); cmp("t3_release", 32'(stall), 0); cmp("t3_fwd_d_rs", 32'(fwd_d_rs), 1);
    cmp("t3_cnt", 32'(stall_cnt), 2);
    adv();

    // div ; mflo
    do_reset();
    set_d(0, 3, 0, 3, 0, 1, 1, 1, 1);
    tick();
    set_d(0, 3, 0, 3, 2, 1, 1, 0, 0);
    nst = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      half();
      if (stall) begin
        nst++;
        adv();
      end else begin
        cmp("t4_stall_len", 32'(nst), 32'(1 + DIV_LAT));
        cmp("t4_busy_drop", 32'(md_busy), 0);
        cmp("t4_cnt", 32'(stall_cnt), 32'(1 + DIV_LAT));
        done = 1;
      end
    end
    cmp("t4_completed", 32'(done), 1);
    adv();

    // $0 everywhere
    set_d(0, 0, 0, 0, 0, 2, 0, 0, 0);
    tick(); tick(); tick();
    half();
    cmp("t5_stall", 32'(stall), 0);
    cmp("t5_fwd", {26'd0, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 0);
    cmp("t5_fwd_m", 32'(fwd_m_rt), 0);
    adv();

    // reset in the middle of a divide (counter at 6)
    do_reset();
    set_d(0, 3, 0, 3, 0, 1, 0, 1, 1);
    tick();
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    set_d(0, 3, 0, 3, 0, 0, 1, 0, 0);
    half(); cmp("t6_busy", 32'(md_busy), 1); cmp("t6_stall", 32'(stall), 1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    cmp("t6_rst_busy", 32'(md_busy), 0);
    cmp("t6_rst_stall", 32'(stall), 0);
    cmp("t6_rst_cnt", 32'(stall_cnt), 0);
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);

    // saturation: repeated div with md_use keeps the unit stalling
    do_reset();
    set_d(0, 3, 0, 3, 0, 1, 1, 1, 1);
    nst = 0;
    for (int k = 0; k < 3000 && nst < CNT_MAX + 4; k++) begin
      half();
      if (stall) nst++;
      adv();
    end
    half();
    cmp("sat_reached", 32'(nst >= CNT_MAX + 4), 1);
    cmp("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    adv();

    // random traffic; D holds while stalled
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (!m_stall_last) begin
        set_d($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              $urandom_range(0, 1));
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
